instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Fetch stage of the pipelined MIPS core: owns the program counter, issues word reads to instruction memory over a req/ack handshake, and holds the fetched instruction in the IF/ID register whose `[31:26]` field drives the control unit's `OP` input. It consumes the control unit's `BranchEQ`/`BranchNE` outputs, together with the ALU `Zero` flag and the resolved target, to redirect fetch and flush wrong-path instructions.

## Interface
- `RESET_PC`, default 32'h0040_0000: PC value loaded on reset.
- `DATA_WIDTH`, default 32: instruction and address width.
- `clk`  in  1  rising-edge clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  read request; held high until `imem_ack`.
- `imem_addr`  out  32  word address of the request (`[1:0]` always 00); stable while `imem_req` is high.
- `imem_ack`  in  1  one-cycle pulse: `imem_rdata` is valid and the request completes.
- `imem_rdata`  in  32  instruction word.
- `id_stall`  in  1  decode cannot accept; IF/ID holds.
- `BranchEQ`, `BranchNE`  in  1 each  branch qualifiers from the execute-stage control.
- `Zero`  in  1  ALU zero flag for the same instruction.
- `branch_target`  in  32  resolved target address; bits `[1:0]` ignored.
- `if_valid`  out  1  IF/ID contents are a live instruction.
- `instr_out`  out  32  IF/ID instruction.
- `op_out`  out  6  `instr_out[31:26]`, fed to the control unit's `OP`.
- `pc_plus4_out`  out  32  address of the IF/ID instruction plus 4.

## Operation
- `take = (BranchEQ & Zero) | (BranchNE & ~Zero)`.
- FSM states: FETCH, HOLD, DRAIN.
  - **FETCH**: `imem_req=1`, `imem_addr=pc`.
    - On `imem_ack` with a free or draining IF/ID, load `instr_out<=imem_rdata`, `pc_plus4_out<=pc+4`, `if_valid<=1`, `pc<=pc+4`.
    - If `imem_ack` arrives while IF/ID holds a valid instruction and `id_stall=1`, the word is stored in a 1-entry skid register and the FSM goes to HOLD.
  - **HOLD**: `imem_req=0`. When `id_stall` falls, the skid word moves to IF/ID and the FSM returns to FETCH.
  - **DRAIN**: entered when `take` occurs while a request is outstanding (`imem_req=1` and no ack this cycle). `imem_req` stays high at the old address until `imem_ack`. Returned data is discarded, then the FSM goes to FETCH.
- Redirect (`take=1`):
  - `pc<={branch_target[31:2],2'b00}`.
  - `if_valid<=0` and skid cleared, regardless of `id_stall`.
  - Next state is FETCH, or DRAIN if a request is outstanding.
  - Redirect has priority over stall and over a same-cycle ack; that ack's data is dropped, and the FSM goes to FETCH because the request completed.
- When IF/ID is not valid, `id_stall` is ignored: there is no bubble to hold.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset values: `pc=RESET_PC`, state FETCH, `if_valid=0`, `instr_out=0`, `op_out=0`, `pc_plus4_out=0`, skid empty. `imem_req=0` while `reset` is high and 1 in the first cycle after deassertion.
- Fetch latency: an ack in cycle N makes the instruction visible on `instr_out` in N+1. Zero-wait memory (ack in the same cycle as req) sustains one instruction per cycle.
- Redirect in cycle N:
  - `if_valid=0` in N+1.
  - Target address on `imem_addr` in N+1 (FETCH), or after the draining ack (DRAIN).
- Reset asserted mid-request abandons it. Memory must tolerate `imem_req` dropping without ack.
- `imem_addr` never changes while `imem_req=1` and ack is low.

## Structure
- Shared package (with the control unit's opcode localparams): `fetch_state_t` {FETCH, HOLD, DRAIN}, `RESET_PC` default, opcode field bounds `OP_MSB=31`, `OP_LSB=26`.
- One sub-module, `fetch_skid_reg`: 1-entry buffer with valid, load, drain and clear.
- PC/FSM logic lives in the top module.

## Test plan
- Reset, zero-wait memory returning 32'h2008_0005 at 0x0040_0000 → cycle 2 after reset: `if_valid=1`, `op_out=6'h08`, `pc_plus4_out=0x0040_0004`; next `imem_addr=0x0040_0004`.
- `id_stall=1` for 3 cycles with IF/ID valid → `instr_out` unchanged, `imem_req=0` after one skid fill, no word lost. Release → skid word appears in the next cycle in order.
- `BranchNE=1`, `Zero=0`, `branch_target=0x0040_0100` while idle-acked → `if_valid=0` next cycle, `imem_addr=0x0040_0100`.
- `BranchEQ=1`, `Zero=1` while a 3-wait request is outstanding → `imem_addr` holds the old address until ack. That data never reaches `instr_out`; the next request is the target.
- `BranchEQ=1`, `Zero=0` → no redirect, sequential fetch continues.
- Reset pulsed mid-request with ack pending → `imem_req=0` during reset; refetch from `RESET_PC` afterwards; PC wrap from 32'hFFFF_FFFC yields `imem_addr=0`.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the fetch stage and the control unit: FSM state type,
// reset PC default and the opcode field of the instruction word.
package instruction_fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DRAIN
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

    localparam int unsigned OP_MSB = 31;
    localparam int unsigned OP_LSB = 26;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

endpackage

// File: rtl/fetch_skid_reg.sv
// One-entry buffer that catches a fetched word when decode is stalled.
module fetch_skid_reg #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             drain,
    input  logic             clear,
    input  logic [WIDTH-1:0] dataIn,
    output logic             valid,
    output logic [WIDTH-1:0] dataOut
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid   <= 1'b0;
            dataOut <= '0;
        end else begin
            // Clear wins so a redirect never leaves a wrong-path word behind.
            if (clear) begin
                valid <= 1'b0;
            end else if (load) begin
                valid <= 1'b1;
            end else if (drain) begin
                valid <= 1'b0;
            end
            if (load && !clear) begin
                dataOut <= dataIn;
            end
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues req/ack reads to instruction memory and
// holds the IF/ID register; branch redirects flush wrong-path work.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req,
    output logic [DATA_WIDTH-1:0]    imem_addr,
    input  logic                     imem_ack,
    input  logic [DATA_WIDTH-1:0]    imem_rdata,
    input  logic                     id_stall,
    input  logic                     BranchEQ,
    input  logic                     BranchNE,
    input  logic                     Zero,
    input  logic [DATA_WIDTH-1:0]    branch_target,
    output logic                     if_valid,
    output logic [DATA_WIDTH-1:0]    instr_out,
    output logic [OP_MSB-OP_LSB:0]   op_out,
    output logic [DATA_WIDTH-1:0]    pc_plus4_out
);

    fetch_state_t          stateQ, stateD;
    logic [DATA_WIDTH-1:0] pcQ, pcD;
    logic [DATA_WIDTH-1:0] drainAddrQ, drainAddrD;
    logic                  ifValidQ, ifValidD;
    logic [DATA_WIDTH-1:0] instrQ, instrD;
    logic [DATA_WIDTH-1:0] pcPlus4Q, pcPlus4D;

    logic                    take;
    logic                    accept;
    logic [DATA_WIDTH-1:0]   pcNext;
    logic [DATA_WIDTH-1:0]   targetAligned;
    logic                    unusedTargetBits;
    logic                    skidLoad, skidDrain, skidClear, skidValid;
    logic [2*DATA_WIDTH-1:0] skidData;

    assign take             = (BranchEQ & Zero) | (BranchNE & ~Zero);
    assign accept           = ~ifValidQ | ~id_stall;
    assign pcNext           = pcQ + DATA_WIDTH'(4);
    assign targetAligned    = {branch_target[DATA_WIDTH-1:2], 2'b00};
    assign unusedTargetBits = ^branch_target[1:0];

    fetch_skid_reg #(
        .WIDTH (2 * DATA_WIDTH)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .load    (skidLoad),
        .drain   (skidDrain),
        .clear   (skidClear),
        .dataIn  ({imem_rdata, pcNext}),
        .valid   (skidValid),
        .dataOut (skidData)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ <= FETCH;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            FETCH: begin
                if (take) begin
                    stateD = imem_ack ? FETCH : DRAIN;
                end else if (imem_ack && !accept) begin
                    stateD = HOLD;
                end
            end
            HOLD: begin
                if (take || !id_stall) begin
                    stateD = FETCH;
                end
            end
            DRAIN: begin
                if (imem_ack) begin
                    stateD = FETCH;
                end
            end
            default: stateD = FETCH;
        endcase
    end

    always_comb begin
        imem_req  = ~reset & (stateQ != HOLD);
        imem_addr = (stateQ == DRAIN) ? drainAddrQ : pcQ;
    end

    always_comb begin
        pcD        = pcQ;
        drainAddrD = drainAddrQ;
        ifValidD   = ifValidQ;
        instrD     = instrQ;
        pcPlus4D   = pcPlus4Q;
        skidLoad   = 1'b0;
        skidDrain  = 1'b0;
        skidClear  = 1'b0;

        // Decode takes the current instruction whenever it is not stalling.
        if (ifValidQ && !id_stall) begin
            ifValidD = 1'b0;
        end

        if (take) begin
            pcD       = targetAligned;
            ifValidD  = 1'b0;
            skidClear = 1'b1;
            if (stateQ == FETCH && !imem_ack) begin
                drainAddrD = pcQ;
            end
        end else begin
            unique case (stateQ)
                FETCH: begin
                    if (imem_ack) begin
                        pcD = pcNext;
                        if (accept) begin
                            instrD   = imem_rdata;
                            pcPlus4D = pcNext;
                            ifValidD = 1'b1;
                        end else begin
                            skidLoad = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (skidValid && !id_stall) begin
                        instrD    = skidData[2*DATA_WIDTH-1:DATA_WIDTH];
                        pcPlus4D  = skidData[DATA_WIDTH-1:0];
                        ifValidD  = 1'b1;
                        skidDrain = 1'b1;
                    end
                end
                DRAIN: ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcQ        <= RESET_PC;
            drainAddrQ <= RESET_PC;
            ifValidQ   <= 1'b0;
            instrQ     <= '0;
            pcPlus4Q   <= '0;
        end else begin
            pcQ        <= pcD;
            drainAddrQ <= drainAddrD;
            ifValidQ   <= ifValidD;
            instrQ     <= instrD;
            pcPlus4Q   <= pcPlus4D;
        end
    end

    assign if_valid     = ifValidQ;
    assign instr_out    = instrQ;
    assign op_out       = instrQ[OP_MSB:OP_LSB];
    assign pc_plus4_out = pcPlus4Q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Cycle-by-cycle directed bench for instruction_fetch_unit; each vector gives
// the inputs for one cycle and the outputs expected in that same cycle.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_stall;
    logic        BranchEQ;
    logic        BranchNE;
    logic        Zero;
    logic [31:0] branch_target;
    logic        if_valid;
    logic [31:0] instr_out;
    logic [5:0]  op_out;
    logic [31:0] pc_plus4_out;

    int checksTotal  = 0;
    int checksPassed = 0;

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        stall;
        logic        beq;
        logic        bne;
        logic        zero;
        logic [31:0] target;
        logic        expReq;
        logic [31:0] expAddr;
        logic        expValid;
        logic [31:0] expInstr;
        logic [31:0] expPc4;
    } vec_t;

    vec_t vecs[16];

    instruction_fetch_unit #(
        .DATA_WIDTH (32),
        .RESET_PC   (32'h0040_0000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .id_stall      (id_stall),
        .BranchEQ      (BranchEQ),
        .BranchNE      (BranchNE),
        .Zero          (Zero),
        .branch_target (branch_target),
        .if_valid      (if_valid),
        .instr_out     (instr_out),
        .op_out        (op_out),
        .pc_plus4_out  (pc_plus4_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic ack, input logic [31:0] rdata, input logic stall,
                                input logic beq, input logic bne, input logic zero,
                                input logic [31:0] target, input logic expReq,
                                input logic [31:0] expAddr, input logic expValid,
                                input logic [31:0] expInstr, input logic [31:0] expPc4);
        vec_t v;
        v.ack = ack;       v.rdata = rdata;       v.stall = stall;
        v.beq = beq;       v.bne = bne;           v.zero = zero;
        v.target = target; v.expReq = expReq;     v.expAddr = expAddr;
        v.expValid = expValid; v.expInstr = expInstr; v.expPc4 = expPc4;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checksTotal++;
        if (act === exp) begin
            checksPassed++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge: drive one cycle, sample before the next posedge.
    task automatic step(input vec_t v, input string tag);
        logic [31:0] expInstr;
        imem_ack      = v.ack;
        imem_rdata    = v.rdata;
        id_stall      = v.stall;
        BranchEQ      = v.beq;
        BranchNE      = v.bne;
        Zero          = v.zero;
        branch_target = v.target;
        expInstr      = v.expInstr;
        #2;
        chk({tag, " imem_req"},     32'(imem_req),     32'(v.expReq));
        chk({tag, " imem_addr"},    imem_addr,         v.expAddr);
        chk({tag, " if_valid"},     32'(if_valid),     32'(v.expValid));
        chk({tag, " instr_out"},    instr_out,         v.expInstr);
        chk({tag, " op_out"},       32'(op_out),       32'(expInstr[31:26]));
        chk({tag, " pc_plus4_out"}, pc_plus4_out,      v.expPc4);
        @(negedge clk);
    endtask

    task automatic checkResetState(input string tag);
        chk({tag, " imem_req"},     32'(imem_req), 32'h0);
        chk({tag, " imem_addr"},    imem_addr,     32'h0040_0000);
        chk({tag, " if_valid"},     32'(if_valid), 32'h0);
        chk({tag, " instr_out"},    instr_out,     32'h0);
        chk({tag, " op_out"},       32'(op_out),   32'h0);
        chk({tag, " pc_plus4_out"}, pc_plus4_out,  32'h0);
    endtask

    initial begin
        //           ack rdata         stl beq bne z  target         req addr          vld instr         pc4
        vecs[0]  = mk(1, 32'h2008_0005, 0, 0, 0, 0, 32'h0,          1, 32'h0040_0000, 0, 32'h0,         32'h0);
        vecs[1]  = mk(1, 32'h8C09_0010, 0, 0, 0, 0, 32'h0,          1, 32'h0040_0004, 1, 32'h2008_0005, 32'h0040_0004);
        vecs[2]  = mk(1, 32'h0109_5020, 1, 0, 0, 0, 32'h0,          1, 32'h0040_0008, 1, 32'h8C09_0010, 32'h0040_0008);
        vecs[3]  = mk(0, 32'h0,         1, 0, 0, 0, 32'h0,          0, 32'h0040_000C, 1, 32'h8C09_0010, 32'h0040_0008);
        vecs[4]  = mk(0, 32'h0,         1, 0, 0, 0, 32'h0,          0, 32'h0040_000C, 1, 32'h8C09_0010, 32'h0040_0008);
        vecs[5]  = mk(0, 32'h0,         0, 0, 0, 0, 32'h0,          0, 32'h0040_000C, 1, 32'h8C09_0010, 32'h0040_0008);
        vecs[6]  = mk(1, 32'hAC0B_0020, 0, 0, 0, 0, 32'h0,          1, 32'h0040_000C, 1, 32'h0109_5020, 32'h0040_000C);
        vecs[7]  = mk(1, 32'h1234_5678, 0, 0, 1, 0, 32'h0040_0103, 1, 32'h0040_0010, 1, 32'hAC0B_0020, 32'h0040_0010);
        vecs[8]  = mk(1, 32'h3C01_0040, 0, 0, 0, 0, 32'h0,          1, 32'h0040_0100, 0, 32'hAC0B_0020, 32'h0040_0010);
        vecs[9]  = mk(1, 32'h2402_0001, 0, 1, 0, 0, 32'h0040_0500, 1, 32'h0040_0104, 1, 32'h3C01_0040, 32'h0040_0104);
        vecs[10] = mk(0, 32'h0,         0, 0, 1, 1, 32'h0040_0600, 1, 32'h0040_0108, 1, 32'h2402_0001, 32'h0040_0108);
        vecs[11] = mk(1, 32'h0810_0000, 0, 0, 0, 0, 32'h0,          1, 32'h0040_0108, 0, 32'h2402_0001, 32'h0040_0108);
        vecs[12] = mk(0, 32'h0,         1, 1, 0, 1, 32'h0040_0200, 1, 32'h0040_010C, 1, 32'h0810_0000, 32'h0040_010C);
        vecs[13] = mk(0, 32'h0,         1, 0, 0, 0, 32'h0,          1, 32'h0040_010C, 0, 32'h0810_0000, 32'h0040_010C);
        vecs[14] = mk(1, 32'hDEAD_BEEF, 0, 0, 0, 0, 32'h0,          1, 32'h0040_010C, 0, 32'h0810_0000, 32'h0040_010C);
        vecs[15] = mk(0, 32'h0,         0, 0, 0, 0, 32'h0,          1, 32'h0040_0200, 0, 32'h0810_0000, 32'h0040_010C);

        reset = 1'b1;
        imem_ack = 1'b0; imem_rdata = '0; id_stall = 1'b0;
        BranchEQ = 1'b0; BranchNE = 1'b0; Zero = 1'b0; branch_target = '0;
        @(negedge clk);
        @(negedge clk);
        #2;
        checkResetState("reset");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            step(vecs[i], $sformatf("vec%0d", i));
        end

        // Redirect while a 3-wait request is outstanding: old address held, data dropped.
        step(mk(0, 32'h0,         0, 1, 0, 1, 32'h0040_0300, 1, 32'h0040_0200, 0, 32'h0810_0000, 32'h0040_010C), "drain0");
        step(mk(0, 32'h0,         0, 0, 0, 0, 32'h0,         1, 32'h0040_0200, 0, 32'h0810_0000, 32'h0040_010C), "drain1");
        step(mk(0, 32'h0,         0, 0, 0, 0, 32'h0,         1, 32'h0040_0200, 0, 32'h0810_0000, 32'h0040_010C), "drain2");
        step(mk(1, 32'hBADB_AD00, 0, 0, 0, 0, 32'h0,         1, 32'h0040_0200, 0, 32'h0810_0000, 32'h0040_010C), "drain3");
        step(mk(1, 32'h2009_0007, 0, 0, 0, 0, 32'h0,         1, 32'h0040_0300, 0, 32'h0810_0000, 32'h0040_010C), "drain4");
        step(mk(0, 32'h0,         0, 0, 0, 0, 32'h0,         1, 32'h0040_0304, 1, 32'h2009_0007, 32'h0040_0304), "drain5");

        // Reset pulsed while a request is pending.
        reset = 1'b1;
        imem_ack = 1'b0;
        #2;
        checkResetState("midreset");
        @(negedge clk);
        reset = 1'b0;
        step(mk(0, 32'h0,         0, 0, 0, 0, 32'h0,         1, 32'h0040_0000, 0, 32'h0,         32'h0), "refetch");

        // Redirect to the top word, then PC wraps to zero.
        step(mk(1, 32'h5555_5555, 0, 0, 1, 0, 32'hFFFF_FFFE, 1, 32'h0040_0000, 0, 32'h0,         32'h0), "wrap0");
        step(mk(1, 32'h1111_2222, 0, 0, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0), "wrap1");
        step(mk(0, 32'h0,         0, 0, 0, 0, 32'h0,         1, 32'h0000_0000, 1, 32'h1111_2222, 32'h0), "wrap2");

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
